phase_pwm_monitor: RTL
======================

PHASE_PWM_MONITOR -- requirements
Module: phase_pwm_monitor

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 10: width of period/high-time counters.
REQ-002 SHALL have parameter MIN_DEAD_TIME, default 2: minimum legal gap in clk ticks between one gate falling and the other rising.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for gate inputs.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pwm_high_in  input  1  sensed high-side gate signal, asynchronous.
REQ-007 SHALL have port pwm_low_in  input  1  sensed low-side gate signal, asynchronous.
REQ-008 SHALL have port clear_fault  input  1  synchronous clear of sticky faults.
REQ-009 SHALL have port duty_cycle  output  COUNTER_WIDTH  last measured high time, in clk ticks.
REQ-010 SHALL have port period  output  COUNTER_WIDTH  last measured period, in clk ticks.
REQ-011 SHALL have port duty_valid  output  1  one-cycle strobe when duty_cycle/period update.
REQ-012 SHALL have port high_z_detected  output  1  both gates low for a full timeout.
REQ-013 SHALL have port shoot_through  output  1  sticky: both gates high simultaneously.
REQ-014 SHALL have port dead_time_fault  output  1  sticky: gap shorter than MIN_DEAD_TIME.

Function
REQ-015 SHALL pass both inputs through SYNC_STAGES flops; all further logic uses synchronized h/l only.
REQ-016 SHALL detect a period boundary on each synchronized h rising edge.
REQ-017 SHALL run FSM states IDLE, MEASURE, STUCK.
REQ-018 IDLE: counters cleared; first h rise -> MEASURE, no duty_valid.
REQ-019 MEASURE: period counter increments each tick; high counter increments each tick h=1; both saturate at all-ones.
REQ-020 MEASURE, h rise: latch period=period counter+1 and duty_cycle=high counter, pulse duty_valid next cycle, restart counters at 0 in the rise cycle (rise cycle counts as tick 0).
REQ-021 MEASURE, period counter saturates: -> STUCK.
REQ-022 STUCK entry: h=1 -> duty_cycle=all-ones; l=1 -> duty_cycle=0; both 0 -> duty_cycle=0, high_z_detected=1; period=all-ones; duty_valid pulses once.
REQ-023 STUCK, h rise: high_z_detected=0, -> MEASURE with counters restarted; no strobe for the incomplete period.
REQ-024 SHALL set shoot_through in any cycle with h=1 and l=1; it holds until clear_fault.
REQ-025 Dead-time: on h fall or l fall, gap counter starts at 0 and increments while h=0 and l=0; on the opposite gate rising, gap < MIN_DEAD_TIME sets dead_time_fault; same-gate re-rise is not checked.
REQ-026 clear_fault coinciding with a new fault condition: set wins.
REQ-027 Latency: h rise on pin -> duty_valid high SYNC_STAGES+1 cycles later.

Reset
REQ-028 rst_n low SHALL asynchronously force FSM=IDLE, all counters, synchronizer flops and outputs to 0.
REQ-029 Reset release mid-PWM SHALL resume in IDLE; first strobe only after two h rises.

Configuration
REQ-030 PHASE_MON_DEADTIME_CHECK_EN defined: REQ-025 gap counter and dead_time_fault logic compiled in.
REQ-031 PHASE_MON_DEADTIME_CHECK_EN undefined: no gap counter; dead_time_fault tied 0; all other behaviour unchanged.

Structure
REQ-032 Shared package phase_pkg SHALL hold the FSM state enum, default COUNTER_WIDTH, and the all-ones saturation constant.
REQ-033 Synchronizer SHALL be sub-module sync_ff (parameterized depth), instantiated once per input.

Verification
REQ-034 h high 256 of 1023 ticks, l complementary with 2-tick gaps -> duty_cycle=256, period=1023, duty_valid each period, no faults.
REQ-035 Gaps of 1 tick (MIN_DEAD_TIME=2) -> dead_time_fault=1 after first violation, stays until clear_fault; macro undefined -> stays 0.
REQ-036 h and l both high 1 tick -> shoot_through=1; clear_fault pulse -> 0; clear_fault concurrent with overlap -> stays 1.
REQ-037 Both inputs low for 1024+ ticks -> STUCK, high_z_detected=1, duty_cycle=0, one duty_valid; h resumes -> high_z_detected=0, next strobe after full period.
REQ-038 h held high 1024+ ticks -> duty_cycle=0x3FF, period=0x3FF.
REQ-039 rst_n asserted mid-period -> all outputs 0 immediately; after release, first duty_valid after second h rise.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared types and constants for the phase-leg PWM monitor.
package phase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STUCK   = 2'd2
    } phase_state_e;

    localparam int DEFAULT_COUNTER_WIDTH = 10;

    localparam logic [DEFAULT_COUNTER_WIDTH-1:0] CNT_ALL_ONES = {DEFAULT_COUNTER_WIDTH{1'b1}};

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous single-bit input; depth set by STAGES.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the raw input one stage further down the chain every clock.
    always_comb begin
        chain_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    // Chain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{1'b0}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/phase_pwm_monitor.sv
// Phase-leg PWM monitor: high-side duty/period measurement, high-Z, shoot-through and,
// when PHASE_MON_DEADTIME_CHECK_EN is defined, dead-time fault detection.
module phase_pwm_monitor
    import phase_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int MIN_DEAD_TIME = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pwm_high_in,
    input  logic                     pwm_low_in,
    input  logic                     clear_fault,
    output logic [COUNTER_WIDTH-1:0] duty_cycle,
    output logic [COUNTER_WIDTH-1:0] period,
    output logic                     duty_valid,
    output logic                     high_z_detected,
    output logic                     shoot_through,
    output logic                     dead_time_fault
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic h_sync;
    logic l_sync;
    logic h_rise;

    phase_state_e             state_q,    state_d;
    logic [COUNTER_WIDTH-1:0] per_cnt_q,  per_cnt_d;
    logic [COUNTER_WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [COUNTER_WIDTH-1:0] duty_q,     duty_d;
    logic [COUNTER_WIDTH-1:0] period_q,   period_d;
    logic                     valid_q,    valid_d;
    logic                     high_z_q,   high_z_d;
    logic                     shoot_q,    shoot_d;
    logic                     h_prev_q,   h_prev_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_high (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_high_in),
        .q     (h_sync)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_low (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_low_in),
        .q     (l_sync)
    );

    assign h_rise = h_sync & ~h_prev_q;

    // Measurement FSM next-state and output computation.
    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        high_cnt_d = high_cnt_q;
        duty_d     = duty_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        high_z_d   = high_z_q;
        h_prev_d   = h_sync;
        // The rise tick is tick 0 of the new period and is itself a high tick.
        case (state_q)
            ST_IDLE: begin
                per_cnt_d  = CNT_ZERO;
                high_cnt_d = CNT_ZERO;
                if (h_rise) begin
                    state_d    = ST_MEASURE;
                    high_cnt_d = CNT_ONE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (h_rise) begin
                    period_d   = per_cnt_q + CNT_ONE;
                    duty_d     = high_cnt_q;
                    valid_d    = 1'b1;
                    per_cnt_d  = CNT_ZERO;
                    high_cnt_d = CNT_ONE;
                end else if (sat_inc(per_cnt_q) == CNT_MAX) begin
                    state_d    = ST_STUCK;
                    period_d   = CNT_MAX;
                    valid_d    = 1'b1;
                    per_cnt_d  = CNT_ZERO;
                    high_cnt_d = CNT_ZERO;
                    if (h_sync) begin
                        duty_d   = CNT_MAX;
                        high_z_d = 1'b0;
                    end else if (l_sync) begin
                        duty_d   = CNT_ZERO;
                        high_z_d = 1'b0;
                    end else begin
                        duty_d   = CNT_ZERO;
                        high_z_d = 1'b1;
                    end
                end else begin
                    per_cnt_d = sat_inc(per_cnt_q);
                    if (h_sync) begin
                        high_cnt_d = sat_inc(high_cnt_q);
                    end else begin
                        high_cnt_d = high_cnt_q;
                    end
                end
            end
            ST_STUCK: begin
                if (h_rise) begin
                    state_d    = ST_MEASURE;
                    high_z_d   = 1'b0;
                    per_cnt_d  = CNT_ZERO;
                    high_cnt_d = CNT_ONE;
                end else begin
                    state_d    = ST_STUCK;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                per_cnt_d  = CNT_ZERO;
                high_cnt_d = CNT_ZERO;
            end
        endcase

        if (h_sync & l_sync) begin
            shoot_d = 1'b1;
        end else if (clear_fault) begin
            shoot_d = 1'b0;
        end else begin
            shoot_d = shoot_q;
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            per_cnt_q  <= CNT_ZERO;
            high_cnt_q <= CNT_ZERO;
            duty_q     <= CNT_ZERO;
            period_q   <= CNT_ZERO;
            valid_q    <= 1'b0;
            high_z_q   <= 1'b0;
            shoot_q    <= 1'b0;
            h_prev_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            high_cnt_q <= high_cnt_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            high_z_q   <= high_z_d;
            shoot_q    <= shoot_d;
            h_prev_q   <= h_prev_d;
        end
    end

`ifdef PHASE_MON_DEADTIME_CHECK_EN
    localparam logic [COUNTER_WIDTH-1:0] MIN_GAP = COUNTER_WIDTH'(MIN_DEAD_TIME);

    logic                     l_prev_q,     l_prev_d;
    logic                     gap_armed_q,  gap_armed_d;
    logic                     gap_from_h_q, gap_from_h_d;
    logic                     dt_fault_q,   dt_fault_d;
    logic [COUNTER_WIDTH-1:0] gap_cnt_q,    gap_cnt_d;
    logic [COUNTER_WIDTH-1:0] gap_cur;
    logic                     h_fall;
    logic                     l_fall;
    logic                     l_rise;
    logic                     opp_rise;
    logic                     gap_short;

    assign h_fall = ~h_sync & h_prev_q;
    assign l_fall = ~l_sync & l_prev_q;
    assign l_rise = l_sync & ~l_prev_q;

    // Gap timing from one gate falling to the opposite gate rising.
    always_comb begin
        l_prev_d = l_sync;
        if (h_fall) begin
            gap_cur      = CNT_ZERO;
            gap_from_h_d = 1'b1;
        end else if (l_fall) begin
            gap_cur      = CNT_ZERO;
            gap_from_h_d = 1'b0;
        end else begin
            gap_cur      = gap_cnt_q;
            gap_from_h_d = gap_from_h_q;
        end

        if (gap_from_h_d) begin
            opp_rise = l_rise;
        end else begin
            opp_rise = h_rise;
        end
        gap_short = (h_fall | l_fall | gap_armed_q) & opp_rise & (gap_cur < MIN_GAP);

        // Any rise closes the gap window, so a same-gate re-rise is never judged.
        if (h_rise | l_rise) begin
            gap_armed_d = 1'b0;
        end else if (h_fall | l_fall) begin
            gap_armed_d = 1'b1;
        end else begin
            gap_armed_d = gap_armed_q;
        end

        if (~h_sync & ~l_sync) begin
            gap_cnt_d = sat_inc(gap_cur);
        end else begin
            gap_cnt_d = gap_cur;
        end

        if (gap_short) begin
            dt_fault_d = 1'b1;
        end else if (clear_fault) begin
            dt_fault_d = 1'b0;
        end else begin
            dt_fault_d = dt_fault_q;
        end
    end

    // Dead-time checker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_prev_q     <= 1'b0;
            gap_armed_q  <= 1'b0;
            gap_from_h_q <= 1'b0;
            dt_fault_q   <= 1'b0;
            gap_cnt_q    <= CNT_ZERO;
        end else begin
            l_prev_q     <= l_prev_d;
            gap_armed_q  <= gap_armed_d;
            gap_from_h_q <= gap_from_h_d;
            dt_fault_q   <= dt_fault_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign dead_time_fault = dt_fault_q;
`else
    assign dead_time_fault = 1'b0;
`endif

    assign duty_cycle      = duty_q;
    assign period          = period_q;
    assign duty_valid      = valid_q;
    assign high_z_detected = high_z_q;
    assign shoot_through   = shoot_q;

endmodule
